// File: rtl/mem_arb_pkg.sv
// Shared encodings for the fetch/memory-stage port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    M_ISSUE = 2'd1,
    M_WAIT  = 2'd2,
    RESP    = 2'd3
  } state_e;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_UNALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/mem_arb_timer.sv
// Access watchdog: counts enabled cycles since the last clear and flags
// expiry on the TIMEOUT-th enabled cycle.
module mem_arb_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one multi-cycle memory port between fetch and
// the memory stage, with unaligned-address and timeout error reporting.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_req,
  input  logic [ADDR_W-1:0] instr_addr,
  input  logic              fetch_en,
  output logic [DATA_W-1:0] instr_rdata,
  output logic              instr_done,
  output logic              instr_stall,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_done,
  output logic              data_stall,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err,
  output logic [1:0]        err_code
);

  state_e            state_q;
  owner_e            owner_q, last_grant_q;
  logic              mem_req_q, mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, instr_rdata_q, data_rdata_q;
  logic              instr_done_q, data_done_q, err_q;
  logic [1:0]        err_code_q;

  logic              instr_elig, any_elig, gnt_is_data, gnt_wr;
  owner_e            gnt_own;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;

  logic              fin;
  owner_e            fin_own;
  logic [DATA_W-1:0] fin_rdata;
  logic [1:0]        fin_code;

  logic              tmr_clr, tmr_en, tmr_expired;

  always_comb begin
    instr_elig  = instr_req & fetch_en;
    any_elig    = instr_elig | data_req;
    gnt_is_data = data_req & (~instr_elig | (last_grant_q == OWN_INSTR));
    gnt_own     = gnt_is_data ? OWN_DATA : OWN_INSTR;
    gnt_addr    = gnt_is_data ? data_addr : instr_addr;
    gnt_wr      = gnt_is_data & data_wr;
    gnt_wdata   = gnt_is_data ? data_wdata : '0;
  end

  // Completion of the current access, whichever path ends it; this drives
  // the registered done/err/rdata pulse seen during RESP.
  always_comb begin
    fin       = 1'b0;
    fin_own   = owner_q;
    fin_rdata = '0;
    fin_code  = ERR_NONE;
    case (state_q)
      IDLE: begin
        if (any_elig && gnt_addr[0]) begin
          fin      = 1'b1;
          fin_own  = gnt_own;
          fin_code = ERR_UNALIGN;
        end
      end
      M_ISSUE, M_WAIT: begin
        if (tmr_expired && !(state_q == M_WAIT && mem_done)) begin
          fin      = 1'b1;
          fin_code = ERR_TIMEOUT;
        end else if (state_q == M_WAIT && mem_done) begin
          fin       = 1'b1;
          fin_rdata = mem_wr_q ? '0 : mem_rdata;
        end
      end
      default: ;
    endcase
  end

  assign tmr_clr = (state_q == IDLE) && any_elig;
  assign tmr_en  = (state_q == M_ISSUE) || (state_q == M_WAIT);

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clr_i     (tmr_clr),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= OWN_INSTR;
      last_grant_q  <= OWN_INSTR;
      mem_req_q     <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      instr_rdata_q <= '0;
      data_rdata_q  <= '0;
      instr_done_q  <= 1'b0;
      data_done_q   <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      instr_done_q <= fin && (fin_own == OWN_INSTR);
      data_done_q  <= fin && (fin_own == OWN_DATA);
      err_q        <= fin && (fin_code != ERR_NONE);
      err_code_q   <= fin ? fin_code : ERR_NONE;
      if (fin && fin_own == OWN_INSTR) instr_rdata_q <= fin_rdata;
      if (fin && fin_own == OWN_DATA)  data_rdata_q  <= fin_rdata;

      case (state_q)
        IDLE: begin
          if (any_elig) begin
            owner_q      <= gnt_own;
            last_grant_q <= gnt_own;
            mem_addr_q   <= gnt_addr;
            mem_wr_q     <= gnt_wr;
            mem_wdata_q  <= gnt_wdata;
            mem_req_q    <= ~gnt_addr[0];
            state_q      <= gnt_addr[0] ? RESP : M_ISSUE;
          end
        end
        M_ISSUE: begin
          if (fin) begin
            mem_req_q <= 1'b0;
            state_q   <= RESP;
          end else if (mem_ready) begin
            mem_req_q <= 1'b0;
            state_q   <= M_WAIT;
          end
        end
        M_WAIT: begin
          if (fin) state_q <= RESP;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_wr      = mem_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign instr_rdata = instr_rdata_q;
  assign data_rdata  = data_rdata_q;
  assign instr_done  = instr_done_q;
  assign data_done   = data_done_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign instr_stall = instr_req & ~instr_done_q;
  assign data_stall  = data_req & ~data_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle-by-cycle stimulus with
// hand-computed expectations, TIMEOUT overridden to 8.
module tb_mem_port_arbiter;

  logic        clk, rst_n;
  logic        instr_req, fetch_en, instr_done, instr_stall;
  logic [15:0] instr_addr, instr_rdata;
  logic        data_req, data_wr, data_done, data_stall;
  logic [15:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_ready, mem_done;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        err;
  logic [1:0]  err_code;

  int vectors = 0;
  int miscompares = 0;

  mem_port_arbiter #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .TIMEOUT (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_req   (instr_req),
    .instr_addr  (instr_addr),
    .fetch_en    (fetch_en),
    .instr_rdata (instr_rdata),
    .instr_done  (instr_done),
    .instr_stall (instr_stall),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_rdata  (data_rdata),
    .data_done   (data_done),
    .data_stall  (data_stall),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_done    (mem_done),
    .mem_rdata   (mem_rdata),
    .err         (err),
    .err_code    (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nxt();
  endtask

  initial begin
    rst_n = 1'b0; fetch_en = 1'b1;
    instr_req = 1'b0; instr_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_addr = '0; data_wdata = '0;
    mem_ready = 1'b0; mem_done = 1'b0; mem_rdata = '0;
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_done", {instr_done, data_done}, 0);
    chk("rst_err", {err, err_code}, 0);
    chk("rst_rdata", {instr_rdata, data_rdata}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nxt();

    // Single load, L=3: done pulse at cycle 5
    data_req = 1'b1; data_wr = 1'b0; data_addr = 16'h0010;
    mid(); chk("t1_stall_c0", data_stall, 1); chk("t1_noreq_c0", mem_req, 0); nxt();
    mem_ready = 1'b1;
    mid(); chk("t1_req_c1", mem_req, 1); chk("t1_addr_c1", mem_addr, 16'h0010); chk("t1_wr_c1", mem_wr, 0); nxt();
    mem_ready = 1'b0;
    mid(); chk("t1_reqdrop_c2", mem_req, 0); chk("t1_stall_c2", data_stall, 1); nxt();
    nxt();
    mem_done = 1'b1; mem_rdata = 16'hBEEF;
    mid(); chk("t1_nodone_c4", data_done, 0); chk("t1_stall_c4", data_stall, 1); nxt();
    mem_done = 1'b0;
    mid();
    chk("t1_done_c5", data_done, 1); chk("t1_rdata_c5", data_rdata, 16'hBEEF);
    chk("t1_stall_c5", data_stall, 0); chk("t1_idone_c5", instr_done, 0); chk("t1_err_c5", err, 0);
    nxt();
    data_req = 1'b0;
    mid(); chk("t1_pulse_end", data_done, 0); chk("t1_rdata_hold", data_rdata, 16'hBEEF); nxt();
    do_reset();

    // Both requesters from reset, L=1: data, instr, then data again
    instr_req = 1'b1; instr_addr = 16'h0100; data_req = 1'b1; data_addr = 16'h0200;
    nxt();
    mem_ready = 1'b1;
    mid(); chk("t2_first_data", mem_addr, 16'h0200); chk("t2_istall", instr_stall, 1); nxt();
    mem_ready = 1'b0; mem_done = 1'b1; mem_rdata = 16'h1111; nxt();
    mem_done = 1'b0;
    mid(); chk("t2_ddone", data_done, 1); chk("t2_drdata", data_rdata, 16'h1111); chk("t2_idone0", instr_done, 0); nxt();
    data_req = 1'b0; nxt();
    mem_ready = 1'b1;
    mid(); chk("t2_instr_req", mem_req, 1); chk("t2_instr_addr", mem_addr, 16'h0100); nxt();
    mem_ready = 1'b0; mem_done = 1'b1; mem_rdata = 16'h2222; nxt();
    mem_done = 1'b0;
    mid(); chk("t2_idone", instr_done, 1); chk("t2_irdata", instr_rdata, 16'h2222); chk("t2_ddone0", data_done, 0); nxt();
    instr_addr = 16'h0102; data_req = 1'b1; data_addr = 16'h0204; nxt();
    mem_ready = 1'b1;
    mid(); chk("t2_rr_data", mem_addr, 16'h0204); nxt();
    mem_ready = 1'b0; mem_done = 1'b1; mem_rdata = 16'h3333; nxt();
    mem_done = 1'b0;
    mid(); chk("t2_ddone2", data_done, 1); chk("t2_drdata2", data_rdata, 16'h3333); nxt();
    data_req = 1'b0; nxt();
    mem_ready = 1'b1;
    mid(); chk("t2_rr_instr", mem_addr, 16'h0102); nxt();
    mem_ready = 1'b0; mem_done = 1'b1; mem_rdata = 16'h4444; nxt();
    mem_done = 1'b0;
    mid(); chk("t2_idone2", instr_done, 1); chk("t2_irdata2", instr_rdata, 16'h4444); nxt();

    // Halted fetch: no grant until fetch_en rises
    fetch_en = 1'b0; instr_addr = 16'h0300;
    for (int i = 0; i < 3; i++) begin
      mid(); chk("t3_halt_noreq", mem_req, 0); chk("t3_halt_stall", instr_stall, 1); nxt();
    end
    fetch_en = 1'b1;
    mid(); chk("t3_en_noreq_yet", mem_req, 0); nxt();
    fetch_en = 1'b0; mem_ready = 1'b1;
    mid(); chk("t3_fetch_req", mem_req, 1); chk("t3_fetch_addr", mem_addr, 16'h0300); nxt();
    mem_ready = 1'b0; mem_done = 1'b1; mem_rdata = 16'h5555; nxt();
    mem_done = 1'b0;
    mid(); chk("t3_inflight_done", instr_done, 1); chk("t3_irdata", instr_rdata, 16'h5555); nxt();

    // Aligned store: rdata returns 0
    instr_req = 1'b0; fetch_en = 1'b1;
    data_req = 1'b1; data_wr = 1'b1; data_addr = 16'h0040; data_wdata = 16'h5A5A;
    mid(); chk("t4_idone_end", instr_done, 0); nxt();
    mem_ready = 1'b1;
    mid();
    chk("t4_st_req", mem_req, 1); chk("t4_st_wr", mem_wr, 1);
    chk("t4_st_wdata", mem_wdata, 16'h5A5A); chk("t4_st_addr", mem_addr, 16'h0040);
    nxt();
    mem_ready = 1'b0; mem_done = 1'b1; mem_rdata = 16'hFFFF; nxt();
    mem_done = 1'b0;
    mid(); chk("t4_st_done", data_done, 1); chk("t4_st_rdata0", data_rdata, 0); chk("t4_st_err", err, 0); nxt();

    // Timeout (TIMEOUT=8): done pulse with err 10 at cycle 9
    data_wr = 1'b0; data_addr = 16'h0050;
    mid(); chk("t5_done_clear", data_done, 0); nxt();
    mem_ready = 1'b1;
    mid(); chk("t5_req", mem_req, 1); chk("t5_addr", mem_addr, 16'h0050); nxt();
    for (int i = 2; i <= 8; i++) begin
      mem_ready = 1'b0;
      mid(); chk("t5_waiting", {data_done, err}, 0); nxt();
    end
    mid();
    chk("t5_to_done", data_done, 1); chk("t5_to_err", err, 1);
    chk("t5_to_code", err_code, 2'b10); chk("t5_to_rdata", data_rdata, 0); chk("t5_to_noreq", mem_req, 0);
    nxt();
    data_req = 1'b0; mem_done = 1'b1; mem_rdata = 16'h7777;
    mid(); chk("t5_late_nodone", {data_done, err}, 0); nxt();
    mem_done = 1'b0; data_req = 1'b1; data_addr = 16'h0060;
    mid(); chk("t5_late_ignored", data_done, 0); chk("t5_late_rdata", data_rdata, 0); nxt();
    mem_ready = 1'b1;
    mid(); chk("t5_next_req", mem_req, 1); chk("t5_next_addr", mem_addr, 16'h0060); nxt();
    mem_ready = 1'b0; mem_done = 1'b1; mem_rdata = 16'h8888; nxt();
    mem_done = 1'b0;
    mid(); chk("t5_next_done", data_done, 1); chk("t5_next_rdata", data_rdata, 16'h8888); chk("t5_next_err", err, 0); nxt();

    // Unaligned store: immediate error response, no memory request
    data_wr = 1'b1; data_addr = 16'h0021; data_wdata = 16'hABCD; nxt();
    mid();
    chk("t6_ua_noreq", mem_req, 0); chk("t6_ua_done", data_done, 1); chk("t6_ua_err", err, 1);
    chk("t6_ua_code", err_code, 2'b01); chk("t6_ua_rdata", data_rdata, 0);
    nxt();
    data_req = 1'b0; data_wr = 1'b0;
    mid(); chk("t6_ua_errend", {err, err_code, data_done}, 0); nxt();

    // Reset during M_WAIT, then a stray mem_done
    data_req = 1'b1; data_addr = 16'h0070; nxt();
    mem_ready = 1'b1;
    mid(); chk("t7_req", mem_req, 1); nxt();
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_memreq", mem_req, 0); chk("t7_rst_addr", mem_addr, 0);
    chk("t7_rst_irdata", instr_rdata, 0); chk("t7_rst_done", {instr_done, data_done, err}, 0);
    data_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    nxt();
    mem_done = 1'b1; mem_rdata = 16'h9999;
    mid(); chk("t7_stray_c0", data_done, 0); nxt();
    mem_done = 1'b0;
    mid(); chk("t7_stray_done", data_done, 0); chk("t7_stray_rdata", data_rdata, 0); chk("t7_idle_noreq", mem_req, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
